// File: rtl/mcontr_pkg.sv
// Shared types and default sizing for the SDRAM command-path arbiter.
// The states and constants here are used by the picker and the top.
package mcontr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int         NCH_DEF     = 4;
  localparam int         CHW_DEF     = 2;
  localparam int         TOW_DEF     = 8;
  localparam logic [7:0] TIMEOUT_DEF = 8'hff;

endpackage

// File: rtl/mcontr_arb_pick.sv
// Combinational winner picker: the lowest urgent index wins outright.
// Otherwise it does a round-robin scan of rq|rq_urgent that starts at rr_ptr.
module mcontr_arb_pick
  import mcontr_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CHW = CHW_DEF
) (
  input  logic [NCH-1:0] rq,
  input  logic [NCH-1:0] rq_urgent,
  input  logic [CHW-1:0] rr_ptr,
  output logic [CHW-1:0] win,
  output logic           win_valid,
  output logic           win_urgent
);

  logic [NCH-1:0] elig_s;
  logic [CHW-1:0] urg_idx_s;
  logic [CHW-1:0] rr_idx_s;
  logic [CHW-1:0] scan_s;
  logic           urg_found_s;
  logic           rr_found_s;

  assign elig_s = rq | rq_urgent;

  // Lowest set urgent bit; the found flag blocks any later (higher) bits.
  always_comb begin
    urg_idx_s   = '0;
    urg_found_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      urg_idx_s   = (rq_urgent[i] && !urg_found_s) ? CHW'(i) : urg_idx_s;
      urg_found_s = urg_found_s | rq_urgent[i];
    end
  end

  // First eligible channel at or after rr_ptr; CHW-bit addition gives the wrap.
  always_comb begin
    rr_idx_s   = '0;
    rr_found_s = 1'b0;
    scan_s     = '0;
    for (int i = 0; i < NCH; i++) begin
      scan_s     = rr_ptr + CHW'(i);
      rr_idx_s   = (elig_s[scan_s] && !rr_found_s) ? scan_s : rr_idx_s;
      rr_found_s = rr_found_s | elig_s[scan_s];
    end
  end

  // Final selection outputs.
  always_comb begin
    win        = urg_found_s ? urg_idx_s : rr_idx_s;
    win_valid  = |elig_s;
    win_urgent = urg_found_s;
  end

endmodule

// File: rtl/mcontr_arbiter.sv
// Sequencer for the shared SDRAM command path: grants one channel with a single-cycle start.
// It holds the bus until that owner releases it, and a watchdog recovers from owners that never release.
module mcontr_arbiter
  import mcontr_pkg::*;
#(
  parameter int           NCH     = NCH_DEF,
  parameter int           CHW     = CHW_DEF,
  parameter int           TOW     = TOW_DEF,
  parameter logic [TOW-1:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk0,
  input  logic           init_n,
  input  logic           en,
  input  logic [NCH-1:0] rq,
  input  logic [NCH-1:0] rq_urgent,
  input  logic [NCH-1:0] prenext,
  output logic [NCH-1:0] start,
  output logic [CHW-1:0] owner,
  output logic           busy,
  output logic           urgent_grant,
  output logic           timeout_err
);

  arb_state_e     state_r,   state_nxt_s;
  logic [NCH-1:0] start_r,   start_nxt_s;
  logic [CHW-1:0] owner_r,   owner_nxt_s;
  logic [CHW-1:0] rr_ptr_r,  rr_ptr_nxt_s;
  logic [TOW-1:0] wdog_r,    wdog_nxt_s;
  logic           busy_r,    busy_nxt_s;
  logic           urg_r,     urg_nxt_s;
  logic           terr_r,    terr_nxt_s;
  logic           grant_s;
  logic [CHW-1:0] win_s;
  logic           win_valid_s;
  logic           win_urgent_s;

  mcontr_arb_pick #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_pick (
    .rq         (rq),
    .rq_urgent  (rq_urgent),
    .rr_ptr     (rr_ptr_r),
    .win        (win_s),
    .win_valid  (win_valid_s),
    .win_urgent (win_urgent_s)
  );

  // Next-state logic: idle grants, back-to-back re-arbitration on release, and the watchdog.
  always_comb begin
    state_nxt_s  = state_r;
    start_nxt_s  = '0;
    owner_nxt_s  = owner_r;
    rr_ptr_nxt_s = rr_ptr_r;
    wdog_nxt_s   = wdog_r;
    busy_nxt_s   = busy_r;
    urg_nxt_s    = urg_r;
    terr_nxt_s   = terr_r;
    grant_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grant_s = en & win_valid_s;
      end
      ST_BUSY: begin
        // Release takes precedence over a watchdog expiry on the same edge.
        if (prenext[owner_r]) begin
          if (en && win_valid_s) begin
            grant_s = 1'b1;
          end else begin
            busy_nxt_s  = 1'b0;
            state_nxt_s = ST_IDLE;
          end
        end else if (wdog_r == TIMEOUT) begin
          terr_nxt_s  = 1'b1;
          busy_nxt_s  = 1'b0;
          state_nxt_s = ST_IDLE;
        end else begin
          wdog_nxt_s = wdog_r + TOW'(1);
        end
      end
      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (grant_s) begin
      start_nxt_s[win_s] = 1'b1;
      owner_nxt_s        = win_s;
      rr_ptr_nxt_s       = win_s + CHW'(1);
      wdog_nxt_s         = '0;
      busy_nxt_s         = 1'b1;
      urg_nxt_s          = win_urgent_s;
      state_nxt_s        = ST_BUSY;
    end else begin
      start_nxt_s = '0;
    end
  end

  // State and output registers on the falling edge of clk0, with synchronous reset.
  always_ff @(negedge clk0) begin
    if (!init_n) begin
      state_r  <= ST_IDLE;
      start_r  <= '0;
      owner_r  <= '0;
      rr_ptr_r <= '0;
      wdog_r   <= '0;
      busy_r   <= 1'b0;
      urg_r    <= 1'b0;
      terr_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      start_r  <= start_nxt_s;
      owner_r  <= owner_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      wdog_r   <= wdog_nxt_s;
      busy_r   <= busy_nxt_s;
      urg_r    <= urg_nxt_s;
      terr_r   <= terr_nxt_s;
    end
  end

  assign start        = start_r;
  assign owner        = owner_r;
  assign busy         = busy_r;
  assign urgent_grant = urg_r;
  assign timeout_err  = terr_r;

endmodule

// File: tb/tb_mcontr_arbiter.sv
// Self-checking bench for mcontr_arbiter: directed scenarios with literal expectations,
// followed by randomized traffic checked every cycle against a behavioural model.
module tb_mcontr_arbiter;

  localparam int TMO = 255;

  logic       clk0;
  logic       init_n;
  logic       en;
  logic [3:0] rq;
  logic [3:0] rq_urgent;
  logic [3:0] prenext;
  logic [3:0] start;
  logic [1:0] owner;
  logic       busy;
  logic       urgent_grant;
  logic       timeout_err;

  mcontr_arbiter #(
    .NCH     (4),
    .CHW     (2),
    .TOW     (8),
    .TIMEOUT (8'hff)
  ) dut (
    .clk0         (clk0),
    .init_n       (init_n),
    .en           (en),
    .rq           (rq),
    .rq_urgent    (rq_urgent),
    .prenext      (prenext),
    .start        (start),
    .owner        (owner),
    .busy         (busy),
    .urgent_grant (urgent_grant),
    .timeout_err  (timeout_err)
  );

  initial clk0 = 1'b1;
  always #5 clk0 = ~clk0;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: what the outputs must be after the next falling edge.
  int   m_start, m_owner, m_rr, m_age;
  bit   m_busy, m_urg, m_terr;
  bit   hang;
  logic [3:0] prev_start;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic pick(output int w, output bit u);
    logic [3:0] e;
    e = rq | rq_urgent;
    w = -1;
    u = (rq_urgent != 4'b0);
    if (u) begin
      for (int k = 3; k >= 0; k--) if (rq_urgent[k]) w = k;
    end else begin
      for (int k = 3; k >= 0; k--) if (e[(m_rr + k) % 4]) w = (m_rr + k) % 4;
    end
  endtask

  task automatic model_step();
    bit g;
    int w;
    bit u;
    g = 0;
    if (!init_n) begin
      m_start = 0; m_owner = 0; m_busy = 0; m_urg = 0; m_terr = 0; m_rr = 0; m_age = 0;
      return;
    end
    m_start = 0;
    if (!m_busy) begin
      g = en && ((rq | rq_urgent) != 4'b0);
    end else if (prenext[m_owner]) begin
      if (en && ((rq | rq_urgent) != 4'b0)) g = 1;
      else m_busy = 0;
    end else if (m_age == TMO) begin
      m_terr = 1;
      m_busy = 0;
    end else begin
      m_age++;
    end
    if (g) begin
      pick(w, u);
      m_start = 1 << w;
      m_owner = w;
      m_busy  = 1;
      m_urg   = u;
      m_rr    = (w + 1) % 4;
      m_age   = 0;
      hang    = ($urandom_range(0, 39) == 0);
    end
  endtask

  task automatic compare_all();
    chk("start", int'(start), m_start);
    chk("owner", int'(owner), m_owner);
    chk("busy", int'(busy), int'(m_busy));
    chk("urgent_grant", int'(urgent_grant), int'(m_urg));
    chk("timeout_err", int'(timeout_err), int'(m_terr));
    chk("start_onehot0", int'($countones(start) <= 1), 1);
    chk("start_repeat", int'((start & prev_start) != 4'b0), 0);
    prev_start = start;
  endtask

  task automatic drive(input logic i_n, input logic e, input logic [3:0] r,
                       input logic [3:0] u, input logic [3:0] p);
    init_n = i_n; en = e; rq = r; rq_urgent = u; prenext = p;
    model_step();
    @(posedge clk0);
    compare_all();
  endtask

  int order [5] = '{1, 2, 3, 1, 2};
  logic [3:0] pn;
  logic [3:0] exp_s;

  initial begin
    prev_start = 4'b0;
    hang = 0;
    m_start = 0; m_owner = 0; m_busy = 0; m_urg = 0; m_terr = 0; m_rr = 0; m_age = 0;

    // 1: reset, single grant, release to idle
    drive(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    drive(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    chk("t1_rst_start", int'(start), 0);
    chk("t1_rst_busy", int'(busy), 0);
    chk("t1_rst_owner", int'(owner), 0);
    drive(1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000);
    chk("t1_start", int'(start), 4'b0001);
    chk("t1_busy", int'(busy), 1);
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001);
    chk("t1_release_busy", int'(busy), 0);

    // 2: round robin 1,2,3,1,2 with back-to-back starts
    drive(1'b1, 1'b1, 4'b1110, 4'b0000, 4'b0000);
    chk("t2_first", int'(start), 4'b0010);
    for (int g = 1; g < 5; g++) begin
      drive(1'b1, 1'b1, 4'b1110, 4'b0000, 4'b0000);
      drive(1'b1, 1'b1, 4'b1110, 4'b0000, 4'b0000);
      pn = 4'b0001 << order[g-1];
      drive(1'b1, 1'b1, 4'b1110, 4'b0000, pn);
      exp_s = 4'b0001 << order[g];
      chk("t2_rr_start", int'(start), int'(exp_s));
      chk("t2_no_gap_busy", int'(busy), 1);
    end
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0100);
    chk("t2_idle", int'(busy), 0);

    // 3: urgent beats round robin, then rr resumes from the wrapped pointer
    drive(1'b1, 1'b1, 4'b0110, 4'b1000, 4'b0000);
    chk("t3_urg_start", int'(start), 4'b1000);
    chk("t3_urg_flag", int'(urgent_grant), 1);
    drive(1'b1, 1'b1, 4'b0110, 4'b0000, 4'b0000);
    drive(1'b1, 1'b1, 4'b0110, 4'b0000, 4'b1000);
    chk("t3_next_start", int'(start), 4'b0010);
    chk("t3_next_urg", int'(urgent_grant), 0);
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0010);

    // 4: watchdog with a stray non-owner prenext
    drive(1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0000);
    chk("t4_start", int'(start), 4'b0100);
    for (int c = 1; c <= TMO; c++)
      drive(1'b1, 1'b1, 4'b0000, 4'b0000, (c == 100) ? 4'b0010 : 4'b0000);
    chk("t4_still_busy", int'(busy), 1);
    chk("t4_no_err_yet", int'(timeout_err), 0);
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    chk("t4_err", int'(timeout_err), 1);
    chk("t4_idle", int'(busy), 0);
    drive(1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000);
    chk("t4_regrant", int'(start), 4'b0001);
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001);

    // 5: en gating
    drive(1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    chk("t5_blocked", int'(start), 0);
    drive(1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000);
    chk("t5_start", int'(start), 4'b0001);
    drive(1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    drive(1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0001);
    chk("t5_done_busy", int'(busy), 0);
    chk("t5_done_start", int'(start), 0);
    drive(1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    chk("t5_still_blocked", int'(start), 0);
    drive(1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000);
    chk("t5_reenabled", int'(start), 4'b0001);
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001);

    // 6: reset on the edge a start would register
    drive(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000);
    chk("t6_start", int'(start), 0);
    chk("t6_terr", int'(timeout_err), 0);
    chk("t6_busy", int'(busy), 0);

    // Random traffic against the model
    for (int c = 0; c < 6000; c++) begin
      logic [3:0] r, u, p;
      logic       e, i;
      i = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 7) != 0);
      r = 4'($urandom);
      u = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      p = 4'($urandom) & 4'($urandom);
      if (m_busy) begin
        p[m_owner] = 1'b0;
        if (m_start == 0 && !hang && $urandom_range(0, 2) == 0) p[m_owner] = 1'b1;
      end
      drive(i, e, r, u, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
